// File: rtl/memory_responder.sv
// memory_responder: two-port round-robin instruction fetch responder over a single-port RAM.
// Program loads take priority and are accepted only while the responder is idle.
module memory_responder #(
  parameter int MEMORY_WIDTH      = 16,
  parameter int MEMORY_ADDR_WIDTH = 11
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         memory_valid_0,
  input  logic [MEMORY_ADDR_WIDTH-1:0] memory_addr_0,
  output logic                         memory_ready_0,
  output logic [MEMORY_WIDTH-1:0]      memory_data_0,
  input  logic                         memory_valid_1,
  input  logic [MEMORY_ADDR_WIDTH-1:0] memory_addr_1,
  output logic                         memory_ready_1,
  output logic [MEMORY_WIDTH-1:0]      memory_data_1,
  input  logic                         load_valid,
  input  logic [MEMORY_ADDR_WIDTH-1:0] load_addr,
  input  logic [MEMORY_WIDTH-1:0]      load_data,
  output logic                         load_ready
);
  typedef enum logic [1:0] {IDLE, GRANT, DATA} state_t;
  state_t                         r_state, w_next;
  logic                           r_last, r_win, w_win, w_grant, w_load;
  logic [MEMORY_ADDR_WIDTH-1:0]   r_addr;
  logic [MEMORY_WIDTH-1:0]        r_rdata, r_data_0, r_data_1;
  logic                           r_ready_0, r_ready_1;
  logic [MEMORY_WIDTH-1:0]        r_mem [2**MEMORY_ADDR_WIDTH];
  always_comb begin
    w_load  = reset && r_state == IDLE && load_valid;
    w_grant = r_state == IDLE && !load_valid && (memory_valid_0 || memory_valid_1);
    // tie goes to the port not granted last; otherwise whichever port is asking
    w_win   = (memory_valid_0 && memory_valid_1) ? !r_last : memory_valid_1;
    w_next  = r_state == GRANT ? DATA :
              r_state == DATA  ? IDLE :
              w_grant          ? GRANT : IDLE;
  end
  // RAM is not reset so that program contents survive a reset
  always_ff @(posedge clk) begin
    if (w_load) r_mem[load_addr] <= load_data;
    else if (r_state == GRANT) r_rdata <= r_mem[r_addr];
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_last    <= 1'b1;
      r_win     <= 1'b0;
      r_addr    <= '0;
      r_ready_0 <= 1'b0;
      r_ready_1 <= 1'b0;
      r_data_0  <= '0;
      r_data_1  <= '0;
    end else begin
      r_state   <= w_next;
      r_ready_0 <= w_grant && !w_win;
      r_ready_1 <= w_grant && w_win;
      if (w_grant) begin
        r_last <= w_win;
        r_win  <= w_win;
        r_addr <= w_win ? memory_addr_1 : memory_addr_0;
      end
      if (r_state == DATA && !r_win) r_data_0 <= r_rdata;
      if (r_state == DATA && r_win) r_data_1 <= r_rdata;
    end
  end
  assign memory_ready_0 = r_ready_0;
  assign memory_ready_1 = r_ready_1;
  assign memory_data_0  = r_data_0;
  assign memory_data_1  = r_data_1;
  assign load_ready     = w_load;
endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: randomized loads/fetches checked against a transaction-level model
// of the RAM contents, round-robin pointer and per-port data outputs.
module tb_memory_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic        memory_valid_0, memory_valid_1, load_valid;
  logic [10:0] memory_addr_0, memory_addr_1, load_addr;
  logic [15:0] load_data, memory_data_0, memory_data_1;
  logic        memory_ready_0, memory_ready_1, load_ready;
  int          n_cmp = 0, n_err = 0;
  logic [15:0] m_mem [2048];
  logic [15:0] m_data [2];
  bit          m_last;
  logic [10:0] pool [$];

  memory_responder dut (
    .clk(clk), .reset(reset),
    .memory_valid_0(memory_valid_0), .memory_addr_0(memory_addr_0),
    .memory_ready_0(memory_ready_0), .memory_data_0(memory_data_0),
    .memory_valid_1(memory_valid_1), .memory_addr_1(memory_addr_1),
    .memory_ready_1(memory_ready_1), .memory_data_1(memory_data_1),
    .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
    .load_ready(load_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [10:0] a, input logic [15:0] d);
    load_valid = 1'b1;
    load_addr  = a;
    load_data  = d;
    #1;
    chk("load_ready", load_ready, 1);
    tick();
    chk("load_no_rdy0", memory_ready_0, 0);
    chk("load_no_rdy1", memory_ready_1, 0);
    m_mem[a]   = d;
    load_valid = 1'b0;
  endtask

  task automatic serve(input bit v0, input bit v1, input logic [10:0] a0, input logic [10:0] a1);
    bit          p0, p1;
    logic [10:0] ad0, ad1;
    p0 = v0; p1 = v1; ad0 = a0; ad1 = a1;
    memory_valid_0 = v0; memory_valid_1 = v1;
    memory_addr_0  = a0; memory_addr_1  = a1;
    while (p0 || p1) begin
      int          n;
      bit          w;
      logic [10:0] wa;
      n = 0;
      do begin tick(); n++; end while (!(memory_ready_0 || memory_ready_1) && n < 4);
      w = (p0 && p1) ? !m_last : p1;
      chk("latency", n, 1);
      chk("ready0", memory_ready_0, !w);
      chk("ready1", memory_ready_1, w);
      if (!(memory_ready_0 || memory_ready_1)) begin
        memory_valid_0 = 1'b0; memory_valid_1 = 1'b0;
        return;
      end
      m_last = w;
      wa = w ? ad1 : ad0;
      // drop the served request and scramble its address: the grant must have latched it
      if (w) begin p1 = 0; memory_valid_1 = 1'b0; memory_addr_1 = 11'($urandom); end
      else   begin p0 = 0; memory_valid_0 = 1'b0; memory_addr_0 = 11'($urandom); end
      if ($urandom_range(0, 1) == 1) begin
        load_valid = 1'b1; load_addr = wa; load_data = ~m_mem[wa];
        #1;
        chk("load_held_off", load_ready, 0);
      end
      tick();
      load_valid = 1'b0;
      chk("data_rdy0_off", memory_ready_0, 0);
      chk("data_rdy1_off", memory_ready_1, 0);
      tick();
      chk(w ? "data1" : "data0", w ? memory_data_1 : memory_data_0, m_mem[wa]);
      chk(w ? "hold0" : "hold1", w ? memory_data_0 : memory_data_1, m_data[!w]);
      m_data[w] = m_mem[wa];
    end
  endtask

  initial begin
    reset = 1'b0;
    memory_valid_0 = 1'b0; memory_valid_1 = 1'b0; load_valid = 1'b0;
    memory_addr_0 = '0; memory_addr_1 = '0; load_addr = '0; load_data = '0;
    m_data[0] = '0; m_data[1] = '0; m_last = 1'b1;
    #1;
    chk("rst_rdy0", memory_ready_0, 0);
    chk("rst_rdy1", memory_ready_1, 0);
    chk("rst_d0", memory_data_0, 0);
    chk("rst_d1", memory_data_1, 0);
    load_valid = 1'b1;
    #1;
    chk("rst_load_ready", load_ready, 0);
    load_valid = 1'b0;
    tick(); tick();
    reset = 1'b1;

    // simultaneous requests right after reset: port 0 wins the first tie
    load(11'h0AD, 16'h1111);
    load(11'h0EF, 16'h2222);
    pool.push_back(11'h0AD);
    pool.push_back(11'h0EF);
    serve(1, 1, 11'h0AD, 11'h0EF);

    load(11'h0EF, 16'h3000);
    serve(1, 0, 11'h0EF, 11'h000);

    // load and fetch together: load first, then fetch returns the new word
    memory_valid_0 = 1'b1; memory_addr_0 = 11'h123;
    load(11'h123, 16'hBEEF);
    pool.push_back(11'h123);
    serve(1, 0, 11'h123, 11'h000);

    // port 1 holds valid across two responses
    memory_valid_1 = 1'b1; memory_addr_1 = 11'h0AD;
    tick();
    chk("hold_r1a", memory_ready_1, 1);
    tick();
    chk("hold_gap1", memory_ready_1, 0);
    tick();
    chk("hold_gap2", memory_ready_1, 0);
    chk("hold_d1a", memory_data_1, m_mem[11'h0AD]);
    tick();
    chk("hold_r1b", memory_ready_1, 1);
    chk("hold_r0", memory_ready_0, 0);
    memory_valid_1 = 1'b0;
    tick(); tick();
    chk("hold_d1b", memory_data_1, m_mem[11'h0AD]);
    chk("hold_d0", memory_data_0, m_data[0]);
    m_data[1] = m_mem[11'h0AD];
    m_last = 1'b1;

    // reset while in GRANT aborts the fetch
    memory_valid_0 = 1'b1; memory_addr_0 = 11'h0EF;
    tick();
    chk("abort_rdy", memory_ready_0, 1);
    memory_valid_0 = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("abort_rdy0", memory_ready_0, 0);
    chk("abort_d0", memory_data_0, 0);
    chk("abort_d1", memory_data_1, 0);
    m_data[0] = '0; m_data[1] = '0; m_last = 1'b1;
    tick();
    chk("abort_idle_rdy0", memory_ready_0, 0);
    tick(); tick();
    chk("abort_idle_d0", memory_data_0, 0);
    reset = 1'b1;
    serve(1, 1, 11'h0AD, 11'h0EF);

    for (int i = 0; i < 12; i++) begin
      logic [10:0] a;
      a = 11'($urandom);
      load(a, 16'($urandom));
      pool.push_back(a);
    end

    for (int i = 0; i < 80; i++) begin
      int          op;
      logic [10:0] a, b;
      bit [1:0]    v;
      op = $urandom_range(0, 3);
      a  = pool[$urandom_range(0, pool.size() - 1)];
      b  = pool[$urandom_range(0, pool.size() - 1)];
      if (op == 0) begin
        a = 11'($urandom);
        load(a, 16'($urandom));
        pool.push_back(a);
      end else if (op == 1) begin
        memory_valid_0 = 1'b1; memory_addr_0 = a;
        load(a, 16'($urandom));
        serve(1, 0, a, 11'h000);
      end else begin
        v = 2'($urandom_range(1, 3));
        serve(v[0], v[1], a, b);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 The block SHALL have parameter MEMORY_WIDTH, default 16, meaning instruction word width.
REQ-002 The block SHALL have parameter MEMORY_ADDR_WIDTH, default 11, meaning word address width; depth = 2^MEMORY_ADDR_WIDTH.
REQ-003 Port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 Port reset  input  1  reset is asynchronous and active-low.
REQ-005 Port memory_valid_0  input  1  fetch request from requester 0.
REQ-006 Port memory_addr_0  input  MEMORY_ADDR_WIDTH  fetch address from requester 0.
REQ-007 Port memory_ready_0  output  1  one-cycle grant pulse to requester 0.
REQ-008 Port memory_data_0  output  MEMORY_WIDTH  fetched word for requester 0.
REQ-009 Ports memory_valid_1, memory_addr_1, memory_ready_1, memory_data_1 SHALL mirror REQ-005..008 for requester 1.
REQ-010 Port load_valid  input  1  program-load write request.
REQ-011 Port load_addr  input  MEMORY_ADDR_WIDTH  program-load address.
REQ-012 Port load_data  input  MEMORY_WIDTH  program-load word.
REQ-013 Port load_ready  output  1  high when a load write is accepted this cycle.

Function
REQ-014 Storage SHALL be a single-port synchronous RAM of 2^MEMORY_ADDR_WIDTH x MEMORY_WIDTH; contents are not cleared by reset.
REQ-015 FSM states SHALL be IDLE, GRANT, DATA; GRANT always goes to DATA, DATA always goes to IDLE.
REQ-016 In IDLE with load_valid=1: write load_data to load_addr at the edge, load_ready=1 that cycle, state stays IDLE; loads take priority over fetches.
REQ-017 load_ready SHALL be combinationally (state==IDLE) AND load_valid; in GRANT/DATA load_valid is held off, no write occurs.
REQ-018 In IDLE with load_valid=0 and any memory_valid_x=1: register winner index and its address, go to GRANT.
REQ-019 Arbitration SHALL be round-robin: if both valid, grant the port not granted last; if only one valid, grant it; last-grant register updates on each grant.
REQ-020 In GRANT: memory_ready of the granted port SHALL be 1 for exactly that cycle (registered output), other port's ready 0; RAM read of registered address launched at the end of GRANT.
REQ-021 In DATA: RAM word SHALL be registered into memory_data of the granted port at the end of DATA, so it is stable from the cycle after DATA until that port's next response.
REQ-022 The non-granted port's memory_data SHALL hold its previous value.
REQ-023 Request-to-ready latency SHALL be 1 cycle (valid seen in IDLE at edge k, ready high in cycle k+1); at most one fetch per 3 cycles.
REQ-024 Requesters drop valid after seeing ready; a valid still high on return to IDLE SHALL be treated as a new request.
REQ-025 Address changes while in GRANT/DATA SHALL be ignored (address registered at grant).

Reset
REQ-026 On reset low: state=IDLE, memory_ready_0/1=0, memory_data_0/1=0, last-grant=1 (port 0 wins first tie), load_ready=0, immediately and asynchronously.
REQ-027 Reset asserted mid-fetch SHALL abort it: no ready pulse or data update after reset; RAM contents retained.
REQ-028 After reset release, the first edge SHALL already evaluate IDLE.

Verification
REQ-029 Load 0x3000 at 0x0EF, then port 0 requests 0x0EF -> memory_ready_0 high one cycle after request, memory_data_0=0x3000 two cycles after ready, memory_ready_1 stays 0.
REQ-030 Both ports valid simultaneously after reset (addr 0x0AD / 0x0EF, preloaded 0x1111 / 0x2222) -> port 0 served first with 0x1111, then port 1 with 0x2222; never both ready in the same cycle.
REQ-031 load_valid and memory_valid_0 high together in IDLE -> load_ready=1, write performed, no ready that cycle; fetch granted on next IDLE cycle and returns newly written word.
REQ-032 Port 1 holds valid across two responses while port 0 idle -> two ready_1 pulses 3 cycles apart, memory_data_0 unchanged.
REQ-033 Reset asserted in GRANT -> memory_ready_x drops to 0 immediately, data outputs 0, preloaded words still read back correctly after release.
